// File: rtl/snake_body_scheduler_if.sv
// Request/stream bundle between the game FSM / VGA tracker side and the body scheduler.
// The scheduler uses the slave view; the game/graphics side uses the master view.
interface snake_body_scheduler_if #(
  parameter int unsigned SNAKE_LENGTH_BIT = 7
);
  logic                        frame_start;
  logic                        init_req;
  logic [6:0]                  init_x;
  logic [6:0]                  init_y;
  logic                        move_req;
  logic                        grow;
  logic [6:0]                  old_head_x;
  logic [6:0]                  old_head_y;
  logic                        init_ack;
  logic                        move_ack;
  logic                        length_full;
  logic [SNAKE_LENGTH_BIT-1:0] snake_length;
  logic [SNAKE_LENGTH_BIT-1:0] body_count;
  logic [6:0]                  snake_body_x;
  logic [6:0]                  snake_body_y;
  logic                        body_valid;
  logic                        stream_busy;

  modport slave (
    input  frame_start, init_req, init_x, init_y, move_req, grow, old_head_x, old_head_y,
    output init_ack, move_ack, length_full, snake_length, body_count, snake_body_x,
           snake_body_y, body_valid, stream_busy
  );

  modport master (
    output frame_start, init_req, init_x, init_y, move_req, grow, old_head_x, old_head_y,
    input  init_ack, move_ack, length_full, snake_length, body_count, snake_body_x,
           snake_body_y, body_valid, stream_busy
  );
endinterface

// File: rtl/snake_body_scheduler.sv
// Snake body store in a circular buffer; serialises init, head-shift moves and the
// per-frame body stream so graphics only ever sees a consistent snake.
module snake_body_scheduler #(
  parameter int unsigned SNAKE_LENGTH_BIT = 7,
  parameter int unsigned SNAKE_LENGTH_MAX = 128,
  parameter int unsigned INIT_LENGTH      = 3
) (
  input  logic                   clock_25,
  input  logic                   reset,
  snake_body_scheduler_if.slave  bus
);

  localparam int unsigned W = SNAKE_LENGTH_BIT;
  localparam logic [W-1:0] LenMax   = W'(SNAKE_LENGTH_MAX - 1);
  localparam logic [W-1:0] InitLast = W'(INIT_LENGTH - 1);
  localparam logic [W-1:0] InitLen  = W'(INIT_LENGTH);
  localparam logic [W-1:0] One      = W'(1);

  typedef enum logic [1:0] {StIdle, StInit, StMove, StStream} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] len_q, len_d;
  logic [W-1:0] k_q, k_d;
  logic         stream_pend_q, stream_pend_d;
  logic         init_ack_q, init_ack_d;
  logic         move_ack_q, move_ack_d;
  logic [W-1:0] snake_length_q, snake_length_d;
  logic [W-1:0] body_count_q;
  logic         body_valid_q;
  logic [13:0]  rd_data_q;

  logic [13:0]  mem_q [SNAKE_LENGTH_MAX];
  logic         we;
  logic [W-1:0] waddr;
  logic [13:0]  wdata;
  logic         rd_en;
  logic [W-1:0] rd_addr;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    len_d          = len_q;
    k_d            = k_q;
    stream_pend_d  = stream_pend_q | (bus.frame_start & (state_q != StStream));
    init_ack_d     = 1'b0;
    move_ack_d     = 1'b0;
    snake_length_d = snake_length_q;
    we             = 1'b0;
    waddr          = ptr_q;
    wdata          = '0;
    rd_en          = 1'b0;
    rd_addr        = ptr_q + k_q;

    unique case (state_q)
      StIdle: begin
        // A request still high in its ack cycle is the one just served; don't rerun it.
        if (bus.init_req && !init_ack_q) begin
          state_d = StInit;
          k_d     = '0;
        end else if (stream_pend_q) begin
          state_d        = StStream;
          k_d            = '0;
          stream_pend_d  = 1'b0;
          snake_length_d = len_q;
        end else if (bus.move_req && !move_ack_q) begin
          state_d = StMove;
        end
      end
      StInit: begin
        we    = 1'b1;
        waddr = k_q;
        wdata = {bus.init_x - 7'd1 - k_q, bus.init_y};
        ptr_d = '0;
        len_d = InitLen;
        k_d   = k_q + One;
        if (k_q == InitLast) begin
          state_d    = StIdle;
          init_ack_d = 1'b1;
        end
      end
      StMove: begin
        ptr_d = ptr_q - One;
        we    = 1'b1;
        waddr = ptr_q - One;
        wdata = {bus.old_head_x, bus.old_head_y};
        if (bus.grow && (len_q != LenMax)) begin
          len_d = len_q + One;
        end
        move_ack_d = 1'b1;
        state_d    = StIdle;
      end
      StStream: begin
        if (len_q == '0) begin
          state_d = StIdle;
        end else begin
          rd_en = 1'b1;
          k_d   = k_q + One;
          if (k_q == len_q - One) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      ptr_q          <= '0;
      len_q          <= '0;
      k_q            <= '0;
      stream_pend_q  <= 1'b0;
      init_ack_q     <= 1'b0;
      move_ack_q     <= 1'b0;
      snake_length_q <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      len_q          <= len_d;
      k_q            <= k_d;
      stream_pend_q  <= stream_pend_d;
      init_ack_q     <= init_ack_d;
      move_ack_q     <= move_ack_d;
      snake_length_q <= snake_length_d;
    end
  end

  always_ff @(posedge clock_25) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register doubles as the stream output, so data and index hold between beats.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      rd_data_q    <= '0;
      body_count_q <= '0;
      body_valid_q <= 1'b0;
    end else begin
      body_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q    <= mem_q[rd_addr];
        body_count_q <= k_q;
      end
    end
  end

  assign bus.init_ack     = init_ack_q;
  assign bus.move_ack     = move_ack_q;
  assign bus.length_full  = (len_q == LenMax);
  assign bus.snake_length = snake_length_q;
  assign bus.body_count   = body_count_q;
  assign bus.snake_body_x = rd_data_q[13:7];
  assign bus.snake_body_y = rd_data_q[6:0];
  assign bus.body_valid   = body_valid_q;
  assign bus.stream_busy  = (state_q == StStream);

endmodule
